// File: rtl/mdbrot_view_ctrl_if.sv
// rtl/mdbrot_view_ctrl_if.sv - command and renderer-facing signals of the view-window controller
interface mdbrot_view_ctrl_if #(
    parameter int MAXBITS = 32
) ();
    logic               cmd_valid;
    logic [2:0]         cmd;
    logic               cmd_ready;
    logic               cmd_err;
    logic               frame_done;
    logic               start;
    logic               busy;
    logic [MAXBITS-1:0] xmin;
    logic [MAXBITS-1:0] xmax;
    logic [MAXBITS-1:0] ymin;
    logic [MAXBITS-1:0] ymax;
    logic [MAXBITS-1:0] Xscale;
    logic [MAXBITS-1:0] Yscale;
    logic [12:0]        max_iter;

    modport master (
        output cmd_valid, cmd, frame_done,
        input  cmd_ready, cmd_err, start, busy,
        input  xmin, xmax, ymin, ymax, Xscale, Yscale, max_iter
    );

    modport slave (
        input  cmd_valid, cmd, frame_done,
        output cmd_ready, cmd_err, start, busy,
        output xmin, xmax, ymin, ymax, Xscale, Yscale, max_iter
    );
endinterface

// File: rtl/mdbrot_view_ctrl.sv
// rtl/mdbrot_view_ctrl.sv - Mandelbrot view window: pan/zoom/reset/redraw, scale divider, frame start
// Optional MDBROT_ITER_SCALE_EN: zoom in/out steps the iteration limit.
module mdbrot_view_ctrl #(
    parameter int MAXBITS      = 32,
    parameter int FPBITS       = 20,
    parameter int XRES         = 160,
    parameter int YRES         = 120,
    parameter int MAX_ITER_DEF = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    mdbrot_view_ctrl_if.slave    bus
);
    localparam int CW  = $clog2(MAXBITS);
    localparam int ONE = 1 << FPBITS;

    localparam logic [MAXBITS-1:0] DEF_XMIN = MAXBITS'(-2 * ONE);
    localparam logic [MAXBITS-1:0] DEF_XMAX = MAXBITS'(ONE);
    localparam logic [MAXBITS-1:0] DEF_YMIN = MAXBITS'(-3 * ONE / 2);
    localparam logic [MAXBITS-1:0] DEF_YMAX = MAXBITS'(3 * ONE / 2);
    localparam logic [MAXBITS-1:0] PAN_LIM  = MAXBITS'(64) << FPBITS;
    localparam logic [MAXBITS-1:0] ZOUT_LIM = MAXBITS'(16) << FPBITS;
    localparam logic [MAXBITS-1:0] XRES_W   = MAXBITS'(XRES);
    localparam logic [MAXBITS-1:0] YRES_W   = MAXBITS'(YRES);
    localparam logic [MAXBITS-2:0] ONE_LSB  = 1;
    localparam logic [CW-1:0]      LAST     = CW'(MAXBITS - 1);
    localparam logic [12:0]        ITER_DEF = 13'(MAX_ITER_DEF);

    typedef enum logic [2:0] {IDLE, APPLY, DIV_X, DIV_Y, START, WAIT} state_t;

    state_t             state, state_n;
    logic [2:0]         cmd_q;
    logic [MAXBITS-1:0] xmin_q, xmax_q, ymin_q, ymax_q;
    logic [MAXBITS-1:0] nxmin, nxmax, nymin, nymax;
    logic [MAXBITS-1:0] w, h;
    logic               refuse;
    logic [MAXBITS-1:0] xscale_q, yscale_q;
    logic [CW-1:0]      cnt_q;
    logic [MAXBITS-1:0] rem_q, dvd_q;
    logic [MAXBITS-1:0] cur_rem, cur_dvd, div_op, div_den, rem_n, dvd_n;
    logic [MAXBITS:0]   trial;

    function automatic logic mag_over(input logic [MAXBITS-1:0] v);
        return v[MAXBITS-1] ? ((-v) > PAN_LIM) : (v > PAN_LIM);
    endfunction

    // Two's complement to sign-magnitude; zero stays positive.
    function automatic logic [MAXBITS-1:0] to_sm(input logic [MAXBITS-1:0] v);
        return v[MAXBITS-1] ? {1'b1, (~v[MAXBITS-2:0]) + ONE_LSB} : v;
    endfunction

    always_comb begin
        w      = xmax_q - xmin_q;
        h      = ymax_q - ymin_q;
        nxmin  = xmin_q;
        nxmax  = xmax_q;
        nymin  = ymin_q;
        nymax  = ymax_q;
        refuse = 1'b0;
        case (cmd_q)
            3'd0: begin nxmin = xmin_q - (w >> 3); nxmax = xmax_q - (w >> 3); end
            3'd1: begin nxmin = xmin_q + (w >> 3); nxmax = xmax_q + (w >> 3); end
            3'd2: begin nymin = ymin_q + (h >> 3); nymax = ymax_q + (h >> 3); end
            3'd3: begin nymin = ymin_q - (h >> 3); nymax = ymax_q - (h >> 3); end
            3'd4: begin
                nxmin  = xmin_q + (w >> 2);
                nxmax  = xmax_q - (w >> 2);
                nymin  = ymin_q + (h >> 2);
                nymax  = ymax_q - (h >> 2);
                refuse = ((w >> 2) < XRES_W) || ((h >> 2) < YRES_W);
            end
            3'd5: begin
                nxmin  = xmin_q - (w >> 1);
                nxmax  = xmax_q + (w >> 1);
                nymin  = ymin_q - (h >> 1);
                nymax  = ymax_q + (h >> 1);
                refuse = (w >= ZOUT_LIM) || (h >= ZOUT_LIM);
            end
            3'd6: begin nxmin = DEF_XMIN; nxmax = DEF_XMAX; nymin = DEF_YMIN; nymax = DEF_YMAX; end
            default: ;
        endcase
        if (!cmd_q[2]) begin
            refuse = mag_over(nxmin) || mag_over(nxmax) || mag_over(nymin) || mag_over(nymax);
        end
    end

    // Restoring divider; quotient bits shift into the dividend register as it empties.
    always_comb begin
        div_op  = (state == DIV_Y) ? h : w;
        div_den = (state == DIV_Y) ? YRES_W : XRES_W;
        cur_rem = (cnt_q == '0) ? '0 : rem_q;
        cur_dvd = (cnt_q == '0) ? div_op : dvd_q;
        trial   = {cur_rem, cur_dvd[MAXBITS-1]};
        if (trial >= {1'b0, div_den}) begin
            rem_n = trial[MAXBITS-1:0] - div_den;
            dvd_n = {cur_dvd[MAXBITS-2:0], 1'b1};
        end else begin
            rem_n = trial[MAXBITS-1:0];
            dvd_n = {cur_dvd[MAXBITS-2:0], 1'b0};
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bus.cmd_valid) state_n = APPLY;
            APPLY:   state_n = refuse ? IDLE : DIV_X;
            DIV_X:   if (cnt_q == LAST) state_n = DIV_Y;
            DIV_Y:   if (cnt_q == LAST) state_n = START;
            START:   state_n = WAIT;
            WAIT:    if (bus.frame_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DIV_X;
            cmd_q    <= '0;
            xmin_q   <= DEF_XMIN;
            xmax_q   <= DEF_XMAX;
            ymin_q   <= DEF_YMIN;
            ymax_q   <= DEF_YMAX;
            xscale_q <= '0;
            yscale_q <= '0;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && bus.cmd_valid) cmd_q <= bus.cmd;
            if (state == APPLY && !refuse) begin
                xmin_q <= nxmin;
                xmax_q <= nxmax;
                ymin_q <= nymin;
                ymax_q <= nymax;
            end
            if (state == DIV_X || state == DIV_Y) begin
                cnt_q <= cnt_q + 1'b1;
                rem_q <= rem_n;
                dvd_q <= dvd_n;
                if (cnt_q == LAST) begin
                    if (state == DIV_X) xscale_q <= dvd_n;
                    else                yscale_q <= dvd_n;
                end
            end
        end
    end

`ifdef MDBROT_ITER_SCALE_EN
    logic [12:0] iter_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            iter_q <= ITER_DEF;
        end else if (state == APPLY && !refuse) begin
            case (cmd_q)
                3'd4:    iter_q <= (iter_q > 13'h1FFF - 13'd64) ? 13'h1FFF : iter_q + 13'd64;
                3'd5:    iter_q <= (iter_q < ITER_DEF + 13'd64) ? ITER_DEF : iter_q - 13'd64;
                3'd6:    iter_q <= ITER_DEF;
                default: ;
            endcase
        end
    end

    assign bus.max_iter = iter_q;
`else
    assign bus.max_iter = ITER_DEF;
`endif

    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.start     = (state == START);
    assign bus.cmd_err   = (state == APPLY) && refuse;
    assign bus.xmin      = to_sm(xmin_q);
    assign bus.xmax      = to_sm(xmax_q);
    assign bus.ymin      = to_sm(ymin_q);
    assign bus.ymax      = to_sm(ymax_q);
    assign bus.Xscale    = xscale_q;
    assign bus.Yscale    = yscale_q;
endmodule

// File: tb/tb_mdbrot_view_ctrl.sv
// tb/tb_mdbrot_view_ctrl.sv - self-checking bench for mdbrot_view_ctrl
module tb_mdbrot_view_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdbrot_view_ctrl_if #(.MAXBITS(32)) bus ();
    mdbrot_view_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    localparam longint ONE = 64'd1 << 20;

    int n_cmp = 0;
    int n_bad = 0;
    longint mx0, mx1, my0, my1;
    int mit;

    typedef struct {
        logic [2:0]  cmd;
        logic        err;
        logic [31:0] xmin, xmax, ymin, ymax, xs, ys;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sm(input longint v);
        logic [31:0] r;
        if (v < 0) begin r = 32'(-v); r[31] = 1'b1; end
        else r = 32'(v);
        return r;
    endfunction

    function automatic longint labs(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        mx0 = -2 * ONE; mx1 = ONE; my0 = -3 * ONE / 2; my1 = 3 * ONE / 2; mit = 256;
    endtask

    task automatic model_cmd(input int c, output bit refused);
        longint w, h, a0, a1, b0, b1;
        w = mx1 - mx0; h = my1 - my0;
        a0 = mx0; a1 = mx1; b0 = my0; b1 = my1;
        refused = 0;
        case (c)
            0: begin a0 -= w / 8; a1 -= w / 8; end
            1: begin a0 += w / 8; a1 += w / 8; end
            2: begin b0 += h / 8; b1 += h / 8; end
            3: begin b0 -= h / 8; b1 -= h / 8; end
            4: begin
                refused = (w / 4 < 160) || (h / 4 < 120);
                a0 += w / 4; a1 -= w / 4; b0 += h / 4; b1 -= h / 4;
            end
            5: begin
                refused = (w >= 16 * ONE) || (h >= 16 * ONE);
                a0 -= w / 2; a1 += w / 2; b0 -= h / 2; b1 += h / 2;
            end
            6: begin a0 = -2 * ONE; a1 = ONE; b0 = -3 * ONE / 2; b1 = 3 * ONE / 2; end
            default: ;
        endcase
        if (c < 4 && (labs(a0) > 64 * ONE || labs(a1) > 64 * ONE ||
                      labs(b0) > 64 * ONE || labs(b1) > 64 * ONE))
            refused = 1;
        if (!refused) begin
            mx0 = a0; mx1 = a1; my0 = b0; my1 = b1;
`ifdef MDBROT_ITER_SCALE_EN
            if (c == 4) mit = (mit + 64 > 8191) ? 8191 : mit + 64;
            if (c == 5) mit = (mit - 64 < 256) ? 256 : mit - 64;
            if (c == 6) mit = 256;
`endif
        end
    endtask

    task automatic check_view(input string tag);
        chk({tag, "_xmin"}, bus.xmin, sm(mx0));
        chk({tag, "_xmax"}, bus.xmax, sm(mx1));
        chk({tag, "_ymin"}, bus.ymin, sm(my0));
        chk({tag, "_ymax"}, bus.ymax, sm(my1));
        chk({tag, "_xscale"}, bus.Xscale, 32'((mx1 - mx0) / 160));
        chk({tag, "_yscale"}, bus.Yscale, 32'((my1 - my0) / 120));
        chk({tag, "_max_iter"}, 32'(bus.max_iter), 32'(mit));
    endtask

    // Entered at cycle R+1 (rst just dropped): checks reset outputs, start at R+65, and one frame.
    task automatic after_reset(input string tag);
        bit early = 0;
        chk({tag, "_rst_xmin"}, bus.xmin, 32'h80200000);
        chk({tag, "_rst_xmax"}, bus.xmax, 32'h00100000);
        chk({tag, "_rst_ymin"}, bus.ymin, 32'h80180000);
        chk({tag, "_rst_ymax"}, bus.ymax, 32'h00180000);
        chk({tag, "_rst_xscale"}, bus.Xscale, 32'd0);
        chk({tag, "_rst_yscale"}, bus.Yscale, 32'd0);
        chk({tag, "_rst_iter"}, 32'(bus.max_iter), 32'd256);
        chk({tag, "_rst_ready"}, 32'(bus.cmd_ready), 32'd0);
        chk({tag, "_rst_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_rst_err"}, 32'(bus.cmd_err), 32'd0);
        for (int k = 1; k < 65; k++) begin
            early |= bus.start;
            @(negedge clk);
        end
        chk({tag, "_no_early_start"}, 32'(early), 32'd0);
        chk({tag, "_start_r65"}, 32'(bus.start), 32'd1);
        @(negedge clk);
        chk({tag, "_start_once"}, 32'(bus.start), 32'd0);
        chk({tag, "_def_xscale"}, bus.Xscale, 32'd19660);
        chk({tag, "_def_yscale"}, bus.Yscale, 32'd26214);
        bus.frame_done = 1'b1;
        @(negedge clk);
        bus.frame_done = 1'b0;
        chk({tag, "_ready_f1"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    task automatic run_cmd(input logic [2:0] c, input bit exp_err);
        int n = 0;
        bit early = 0;
        while (bus.cmd_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        chk("ready_before_cmd", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd = c;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("cmd_err_t1", 32'(bus.cmd_err), 32'(exp_err));
        @(negedge clk);
        if (exp_err) begin
            chk("ready_after_refuse", 32'(bus.cmd_ready), 32'd1);
            chk("err_one_cycle", 32'(bus.cmd_err), 32'd0);
            return;
        end
        chk("busy_t2", 32'(bus.busy), 32'd1);
        for (int k = 2; k < 66; k++) begin
            early |= bus.start;
            bus.frame_done = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        chk("no_early_start", 32'(early), 32'd0);
        chk("start_t66", 32'(bus.start), 32'd1);
        bus.frame_done = 1'b1;
        @(negedge clk);
        bus.frame_done = 1'b0;
        chk("fd_in_start_ignored", 32'(bus.cmd_ready), 32'd0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.frame_done = 1'b1;
        @(negedge clk);
        bus.frame_done = 1'b0;
        chk("ready_f1", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        bit r, acc, done;
        int n;
        logic [2:0] c;

        tbl[0] = '{3'd1, 1'b0, 32'h801A0000, 32'h00160000, 32'h80180000, 32'h00180000, 32'd19660, 32'd26214};
        tbl[1] = '{3'd6, 1'b0, 32'h80200000, 32'h00100000, 32'h80180000, 32'h00180000, 32'd19660, 32'd26214};
        tbl[2] = '{3'd4, 1'b0, 32'h80140000, 32'h00040000, 32'h800C0000, 32'h000C0000, 32'd9830, 32'd13107};
        tbl[3] = '{3'd6, 1'b0, 32'h80200000, 32'h00100000, 32'h80180000, 32'h00180000, 32'd19660, 32'd26214};
        tbl[4] = '{3'd5, 1'b0, 32'h80380000, 32'h00280000, 32'h80300000, 32'h00300000, 32'd39321, 32'd52428};
        tbl[5] = '{3'd5, 1'b0, 32'h80680000, 32'h00580000, 32'h80600000, 32'h00600000, 32'd78643, 32'd104857};
        tbl[6] = '{3'd5, 1'b0, 32'h80C80000, 32'h00B80000, 32'h80C00000, 32'h00C00000, 32'd157286, 32'd209715};
        tbl[7] = '{3'd5, 1'b1, 32'h80C80000, 32'h00B80000, 32'h80C00000, 32'h00C00000, 32'd157286, 32'd209715};
        tbl[8] = '{3'd7, 1'b0, 32'h80C80000, 32'h00B80000, 32'h80C00000, 32'h00C00000, 32'd157286, 32'd209715};
        tbl[9] = '{3'd3, 1'b0, 32'h80C80000, 32'h00B80000, 32'h80F00000, 32'h00900000, 32'd157286, 32'd209715};

        bus.cmd_valid = 1'b0;
        bus.cmd = 3'd0;
        bus.frame_done = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        after_reset("init");

        for (int i = 0; i < 10; i++) begin
            model_cmd(int'(tbl[i].cmd), r);
            run_cmd(tbl[i].cmd, tbl[i].err);
            chk($sformatf("tbl%0d_xmin", i), bus.xmin, tbl[i].xmin);
            chk($sformatf("tbl%0d_xmax", i), bus.xmax, tbl[i].xmax);
            chk($sformatf("tbl%0d_ymin", i), bus.ymin, tbl[i].ymin);
            chk($sformatf("tbl%0d_ymax", i), bus.ymax, tbl[i].ymax);
            chk($sformatf("tbl%0d_xscale", i), bus.Xscale, tbl[i].xs);
            chk($sformatf("tbl%0d_yscale", i), bus.Yscale, tbl[i].ys);
            chk($sformatf("tbl%0d_iter", i), 32'(bus.max_iter), 32'(mit));
        end

        // Command held through WAIT is only taken once IDLE is reached.
        bus.cmd_valid = 1'b1;
        bus.cmd = 3'd7;
        @(negedge clk);
        chk("hold_busy_t1", 32'(bus.busy), 32'd1);
        n = 0;
        while (bus.start !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("hold_start_seen", 32'(bus.start), 32'd1);
        @(negedge clk);
        acc = 0;
        repeat (8) begin acc |= bus.cmd_ready | bus.start; @(negedge clk); end
        chk("hold_no_accept_in_wait", 32'(acc), 32'd0);
        check_view("hold_wait");
        bus.frame_done = 1'b1;
        @(negedge clk);
        bus.frame_done = 1'b0;
        chk("hold_ready_f1", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("hold_taken_f2", 32'(bus.busy), 32'd1);
        n = 0;
        while (bus.start !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("hold_second_start", 32'(bus.start), 32'd1);
        @(negedge clk);
        bus.frame_done = 1'b1;
        @(negedge clk);
        bus.frame_done = 1'b0;
        check_view("hold_after");

        // Zoom in until the scale would underflow.
        model_cmd(6, r);
        run_cmd(3'd6, r);
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            model_cmd(4, r);
            run_cmd(3'd4, r);
            check_view("zin");
            done = r;
        end
        chk("zin_reached_refusal", 32'(done), 32'd1);

        // Pan left from a wide view until an edge would pass 64.0.
        model_cmd(6, r);
        run_cmd(3'd6, r);
        repeat (3) begin model_cmd(5, r); run_cmd(3'd5, r); end
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            model_cmd(0, r);
            run_cmd(3'd0, r);
            check_view("pan");
            done = r;
        end
        chk("pan_reached_refusal", 32'(done), 32'd1);

        for (int i = 0; i < 60; i++) begin
            c = 3'($urandom_range(0, 7));
            model_cmd(int'(c), r);
            run_cmd(c, r);
            check_view($sformatf("rnd%0d", i));
        end

        // Reset during DIV_X after a zoom in.
        model_cmd(6, r);
        run_cmd(3'd6, r);
        bus.cmd_valid = 1'b1;
        bus.cmd = 3'd4;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (19) @(negedge clk);
        chk("mid_zoomed_xmin", bus.xmin, 32'h80140000);
        chk("mid_old_xscale", bus.Xscale, 32'd19660);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        after_reset("mid");
        check_view("mid_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
